// File: rtl/checkpoint_rollback_unit_if.sv
// Handshake bundle between dispatch/branch unit and the branch checkpoint table.
// The master drives allocation, resolution and age context; the slave returns grants and flush results.
interface checkpoint_rollback_unit_if #(
    parameter int AL_SIZE     = 32,
    parameter int NUM_CKPT    = 4,
    parameter int NUM_ENTRIES = 8
);
    localparam int PTR_W  = $clog2(AL_SIZE);
    localparam int CKPT_W = $clog2(NUM_CKPT);

    logic                              alloc_req;
    logic [PTR_W:0]                    alloc_ptr;
    logic                              alloc_ready;
    logic [CKPT_W-1:0]                 alloc_id;
    logic                              resolve_valid;
    logic [CKPT_W-1:0]                 resolve_id;
    logic                              resolve_mispr;
    logic [PTR_W:0]                    al_head;
    logic [NUM_ENTRIES*(PTR_W+1)-1:0]  entry_ptr;
    logic [NUM_ENTRIES-1:0]            entry_valid;
    logic                              flush_valid;
    logic [NUM_ENTRIES-1:0]            flush_mask;
    logic [PTR_W:0]                    restore_ptr;
    logic                              busy;
    logic [CKPT_W:0]                   free_count;

    modport master (
        output alloc_req, alloc_ptr, resolve_valid, resolve_id, resolve_mispr,
               al_head, entry_ptr, entry_valid,
        input  alloc_ready, alloc_id, flush_valid, flush_mask, restore_ptr,
               busy, free_count
    );

    modport slave (
        input  alloc_req, alloc_ptr, resolve_valid, resolve_id, resolve_mispr,
               al_head, entry_ptr, entry_valid,
        output alloc_ready, alloc_id, flush_valid, flush_mask, restore_ptr,
               busy, free_count
    );
endinterface

// File: rtl/checkpoint_rollback_unit.sv
// Branch checkpoint table: one slot per in-flight branch, freed on correct resolve,
// and a timed IDLE->FLUSH->RECOVER rollback with a wrap-safe flush mask on mispredict.
module checkpoint_rollback_unit #(
    parameter int AL_SIZE        = 32,
    parameter int NUM_CKPT       = 4,
    parameter int NUM_ENTRIES    = 8,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    checkpoint_rollback_unit_if.slave bus
);
    localparam int PTR_W  = $clog2(AL_SIZE);
    localparam int PW     = PTR_W + 1;
    localparam int CKPT_W = $clog2(NUM_CKPT);
    localparam int CNT_W  = $clog2(RECOVER_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W:0]         ckpt_ptr [NUM_CKPT];
    logic [NUM_CKPT-1:0]    ckpt_busy, busy_next;
    logic [NUM_ENTRIES-1:0] mask_q, mask_d;
    logic [PTR_W:0]         restore_q;
    logic [CKPT_W-1:0]      free_id;
    logic                   free_any;
    logic [CKPT_W:0]        free_cnt;
    logic                   idle, do_alloc, do_free, do_mispr;
    logic [PTR_W:0]         mispr_off;

    // Age is the distance from the AL head; modular subtraction makes it wrap-safe.
    function automatic logic [PTR_W:0] age_off(input logic [PTR_W:0] x, input logic [PTR_W:0] head);
        return x - head;
    endfunction

    always_comb begin
        free_id  = '0;
        free_any = 1'b0;
        free_cnt = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!ckpt_busy[i]) begin
                free_id  = CKPT_W'(i);
                free_any = 1'b1;
            end
            free_cnt = free_cnt + (CKPT_W+1)'(!ckpt_busy[i]);
        end
    end

    assign idle     = (state_q == IDLE);
    assign do_mispr = idle && bus.resolve_valid && bus.resolve_mispr && ckpt_busy[bus.resolve_id];
    assign do_free  = idle && bus.resolve_valid && !bus.resolve_mispr && ckpt_busy[bus.resolve_id];
    assign do_alloc = bus.alloc_req && bus.alloc_ready && !do_mispr;
    assign mispr_off = age_off(ckpt_ptr[bus.resolve_id], bus.al_head);

    // A mispredict squashes the branch's own slot plus every younger one; otherwise
    // correct-resolve and allocate touch different slots, so both can land together.
    always_comb begin
        busy_next = ckpt_busy;
        mask_d    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            mask_d[i] = bus.entry_valid[i] &&
                        (age_off(bus.entry_ptr[i*PW +: PW], bus.al_head) > mispr_off);
        end
        if (do_mispr) begin
            for (int j = 0; j < NUM_CKPT; j++) begin
                if ((CKPT_W'(j) == bus.resolve_id) ||
                    (age_off(ckpt_ptr[j], bus.al_head) > mispr_off)) begin
                    busy_next[j] = 1'b0;
                end
            end
        end else begin
            if (do_free)  busy_next[bus.resolve_id] = 1'b0;
            if (do_alloc) busy_next[free_id]        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (do_mispr) state_d = FLUSH;
            end
            FLUSH: begin
                if (RECOVER_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckpt_busy <= '0;
            mask_q    <= '0;
            restore_q <= '0;
            for (int k = 0; k < NUM_CKPT; k++) ckpt_ptr[k] <= '0;
        end else begin
            ckpt_busy <= busy_next;
            if (do_alloc) ckpt_ptr[free_id] <= bus.alloc_ptr;
            if (do_mispr) begin
                mask_q    <= mask_d;
                restore_q <= ckpt_ptr[bus.resolve_id] + PW'(1);
            end
        end
    end

    assign bus.alloc_ready = idle && free_any;
    assign bus.alloc_id    = free_id;
    assign bus.free_count  = free_cnt;
    assign bus.busy        = !idle;
    assign bus.flush_valid = (state_q == FLUSH);
    assign bus.flush_mask  = mask_q;
    assign bus.restore_ptr = restore_q;
endmodule
